// File: rtl/rom_pkg.sv
// Shared width encodings, FSM states and byte-count helper for the ROM word reader.
package rom_pkg;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10,
        WIDTH_RSVD = 2'b11
    } width_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Reserved width reports 4 bytes; it is rejected before the count is used.
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width_e'(width))
            WIDTH_BYTE: byte_count = 3'd1;
            WIDTH_HALF: byte_count = 3'd2;
            default:    byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/rom_byte_array.sv
// Read-only byte store with a combinational read port. The image named by INIT_FILE is
// preloaded into mem by the surrounding flow; this block never writes it.
module rom_byte_array #(
    parameter int DEPTH     = 512,
    parameter     INIT_FILE = "../main/riscv_cpu.mif"
) (
    input  logic [31:0] addr,
    output logic [7:0]  data
);
    localparam int BYTES = 4 * DEPTH;
    localparam int AW    = $clog2(BYTES);

    logic [7:0] mem [BYTES];

    always_comb begin
        data = 8'h00;
        if (addr < 32'(BYTES)) begin
            data = mem[addr[AW-1:0]];
        end
    end

endmodule

// File: rtl/rom_word_reader.sv
// Byte-serial ROM reader: assembles 1/2/4 little-endian bytes, optionally sign-extended.
// IDLE: wait for req | FETCH: one byte per cycle | DONE: valid pulse, back to IDLE
module rom_word_reader
    import rom_pkg::*;
#(
    parameter int DEPTH     = 512,
    parameter     INIT_FILE = "../main/riscv_cpu.mif"
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] address,
    input  logic [1:0]  width,
    input  logic        sign_extend,
    output logic        busy,
    output logic        valid,
    output logic [31:0] read_data,
    output logic        illegal_address
);
    localparam logic [32:0] ROM_BYTES = 33'(4 * DEPTH);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  idx_q, idx_d;
    logic        sext_q, sext_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] rdata_q, rdata_d;
    logic        illegal_q, illegal_d;

    logic [2:0]  req_n;
    logic [32:0] req_end;
    logic [31:0] rom_addr;
    logic [7:0]  rom_byte;

    assign rom_addr = addr_q + {30'd0, idx_q};

    rom_byte_array #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .addr (rom_addr),
        .data (rom_byte)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        last_d    = last_q;
        idx_d     = idx_q;
        sext_d    = sext_q;
        asm_d     = asm_q;
        rdata_d   = rdata_q;
        illegal_d = illegal_q;
        req_n     = byte_count(width);
        // 33-bit end address so a request near 2^32 cannot wrap into range
        req_end   = {1'b0, address} + {30'd0, req_n} - 33'd1;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d = address;
                    last_d = 2'(req_n - 3'd1);
                    sext_d = sign_extend;
                    idx_d  = 2'd0;
                    asm_d  = 32'd0;
                    if ((width == WIDTH_RSVD) || (req_end >= ROM_BYTES)) begin
                        state_d   = S_DONE;
                        rdata_d   = 32'd0;
                        illegal_d = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                asm_d[{idx_q, 3'b000} +: 8] = rom_byte;
                idx_d = idx_q + 2'd1;
                if (idx_q == last_q) begin
                    state_d   = S_DONE;
                    illegal_d = 1'b0;
                    case (last_q)
                        2'd0:    rdata_d = {{24{sext_q & asm_d[7]}}, asm_d[7:0]};
                        2'd1:    rdata_d = {{16{sext_q & asm_d[15]}}, asm_d[15:0]};
                        default: rdata_d = asm_d;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'd0;
            last_q    <= 2'd0;
            idx_q     <= 2'd0;
            sext_q    <= 1'b0;
            asm_q     <= 32'd0;
            rdata_q   <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            sext_q    <= sext_d;
            asm_q     <= asm_d;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign valid           = (state_q == S_DONE);
    assign read_data       = rdata_q;
    assign illegal_address = illegal_q;

endmodule

// File: tb/tb_rom_word_reader.sv
// Scoreboard bench for rom_word_reader: directed requests push expectations, a monitor checks each valid.
module tb_rom_word_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [31:0] address = 32'd0;
    logic [1:0]  width = 2'b00;
    logic        sign_extend = 1'b0;
    logic        busy;
    logic        valid;
    logic [31:0] read_data;
    logic        illegal_address;

    rom_word_reader #(
        .DEPTH     (512),
        .INIT_FILE ("../main/riscv_cpu.mif")
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req             (req),
        .address         (address),
        .width           (width),
        .sign_extend     (sign_extend),
        .busy            (busy),
        .valid           (valid),
        .read_data       (read_data),
        .illegal_address (illegal_address)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        ill;
        int          vcyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(posedge clock) begin
        #1;
        if (valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got valid at cycle %0d, expected no valid", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_data"}, read_data, mon_e.data);
                chk({mon_e.name, "_illegal"}, {31'd0, illegal_address}, {31'd0, mon_e.ill});
                chk({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.vcyc));
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clock);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: got %0d pending results, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clock);
        #1;
    endtask

    // Called 1 time unit after an edge with the DUT idle; req is sampled at the next edge.
    task automatic issue(input string name, input logic [31:0] a, input logic [1:0] w,
                         input logic sx, input logic [31:0] ed, input logic ei, input int lat);
        exp_t x;
        address     = a;
        width       = w;
        sign_extend = sx;
        req         = 1'b1;
        x.data = ed;
        x.ill  = ei;
        x.vcyc = cyc + lat;
        x.name = name;
        sb.push_back(x);
        @(posedge clock);
        #1;
        req = 1'b0;
        #1;
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        for (int i = 0; i < 2048; i++) dut.u_rom.mem[i] = 8'(i);
        dut.u_rom.mem[0] = 8'h11; dut.u_rom.mem[1] = 8'h22;
        dut.u_rom.mem[2] = 8'h33; dut.u_rom.mem[3] = 8'h44;
        dut.u_rom.mem[4] = 8'h85; dut.u_rom.mem[5] = 8'h66;
        dut.u_rom.mem[6] = 8'h77; dut.u_rom.mem[7] = 8'h88;

        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_data", read_data, 32'd0);
        chk("reset_illegal", {31'd0, illegal_address}, 32'd0);
        #11 reset = 1'b0;
        @(posedge clock);
        #1;

        issue("word_0", 32'd0, 2'b10, 1'b0, 32'h44332211, 1'b0, 5);
        repeat (3) @(posedge clock);
        #1;
        chk("hold_data", read_data, 32'h44332211);
        issue("half_3_sx", 32'd3, 2'b01, 1'b1, 32'hFFFF8544, 1'b0, 3);
        issue("half_3_zx", 32'd3, 2'b01, 1'b0, 32'h00008544, 1'b0, 3);
        issue("word_2045", 32'd2045, 2'b10, 1'b0, 32'h0, 1'b1, 1);
        repeat (2) @(posedge clock);
        #1;
        chk("hold_illegal", {31'd0, illegal_address}, 32'd1);
        issue("byte_2047", 32'd2047, 2'b00, 1'b1, 32'hFFFFFFFF, 1'b0, 2);
        issue("rsvd_0", 32'd0, 2'b11, 1'b0, 32'h0, 1'b1, 1);
        issue("word_wrap", 32'hFFFFFFFE, 2'b10, 1'b0, 32'h0, 1'b1, 1);
        issue("byte_4_sx", 32'd4, 2'b00, 1'b1, 32'hFFFFFF85, 1'b0, 2);
        issue("word_5_misal", 32'd5, 2'b10, 1'b0, 32'h08887766, 1'b0, 5);
        issue("half_2046", 32'd2046, 2'b01, 1'b0, 32'h0000FFFE, 1'b0, 3);
        issue("half_2047", 32'd2047, 2'b01, 1'b0, 32'h0, 1'b1, 1);
        issue("word_4_sx", 32'd4, 2'b10, 1'b1, 32'h88776685, 1'b0, 5);

        // Abort a word read with reset two cycles in; no valid may follow.
        address = 32'd0; width = 2'b10; sign_extend = 1'b0; req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, valid}, 32'd0);
        chk("abort_data", read_data, 32'd0);
        chk("abort_illegal", {31'd0, illegal_address}, 32'd0);
        @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        issue("byte_4_post_rst", 32'd4, 2'b00, 1'b0, 32'h00000085, 1'b0, 2);

        // req held high: second access is sampled the cycle after valid.
        address = 32'd0; width = 2'b10; sign_extend = 1'b0; req = 1'b1;
        s = cyc + 1;
        sb.push_back('{32'h44332211, 1'b0, s + 4, "b2b_first"});
        sb.push_back('{32'h44332211, 1'b0, s + 10, "b2b_second"});
        repeat (7) @(posedge clock);
        #1 req = 1'b0;
        #1;
        wait_done();

        // req pulses while busy must not create another access.
        address = 32'd4; width = 2'b10; sign_extend = 1'b0; req = 1'b1;
        sb.push_back('{32'h88776685, 1'b0, cyc + 5, "busy_word_4"});
        @(posedge clock);
        #1 req = 1'b0;
        @(posedge clock);
        #1;
        chk("busy_high", {31'd0, busy}, 32'd1);
        address = 32'd0; width = 2'b00; req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        @(posedge clock);
        #1 req = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        #1;
        wait_done();
        repeat (6) @(posedge clock);
        #1;
        chk("idle_after_pulses", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_word_reader.md
ROM_WORD_READER -- requirements
Module: rom_word_reader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 512, meaning ROM size in 32-bit words; byte capacity is 4*DEPTH.
REQ-002 The block SHALL have parameter INIT_FILE, default "../main/riscv_cpu.mif", meaning the byte-array init image; contents are never written by the block.
REQ-003 The block SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 1, meaning start a read; sampled only in IDLE.
REQ-006 The block SHALL have port address, input, 32, meaning byte address of the access, captured with req.
REQ-007 The block SHALL have port width, input, 2, meaning 00 byte, 01 halfword, 10 word, 11 reserved; captured with req.
REQ-008 The block SHALL have port sign_extend, input, 1, meaning sign-extend byte/halfword results; captured with req.
REQ-009 The block SHALL have port busy, output, 1, meaning an access is in progress.
REQ-010 The block SHALL have port valid, output, 1, meaning one-cycle pulse marking read_data/illegal_address as final.
REQ-011 The block SHALL have port read_data, output, 32, meaning assembled, extended result.
REQ-012 The block SHALL have port illegal_address, output, 1, meaning the completed access was out of range or width 11.

Function
REQ-013 FSM states SHALL be IDLE, FETCH, DONE.
REQ-014 In IDLE with req=1, the block SHALL capture address/width/sign_extend, set n = 1/2/4 bytes, and go to FETCH if legal, else DONE with an error flag.
REQ-015 An access SHALL be illegal when width=11 or address+n-1 >= 4*DEPTH, computed in 33 bits so no 32-bit wrap hides an overflow.
REQ-016 Misaligned addresses SHALL be legal; no alignment check.
REQ-017 FETCH SHALL read exactly one byte per cycle from address+i, i = 0..n-1, placing byte i at read_data bits [8i+7:8i] (little-endian).
REQ-018 After the last byte, FETCH SHALL go to DONE; DONE SHALL assert valid for exactly one cycle and return to IDLE.
REQ-019 Latency from the req-sampling edge to valid high SHALL be n+1 cycles for legal accesses and 1 cycle for illegal ones.
REQ-020 At valid, bytes above n SHALL be zero, or copies of the top fetched bit when sign_extend=1; width=10 ignores sign_extend.
REQ-021 On an illegal access, valid SHALL pulse with illegal_address=1 and read_data=0; no byte is read.
REQ-022 busy SHALL be high in FETCH and DONE, low in IDLE; req while busy SHALL be ignored (no queueing).
REQ-023 read_data and illegal_address SHALL hold their last completed values until the next valid pulse.
REQ-024 req asserted in the same cycle as valid SHALL be ignored; the new request is accepted the following cycle in IDLE.

Reset
REQ-025 reset SHALL immediately force IDLE, busy=0, valid=0, read_data=0, illegal_address=0, regardless of clock.
REQ-026 Reset mid-access SHALL abort it with no valid pulse; the first post-reset req SHALL behave as from power-up.

Structure
REQ-027 Width encodings, state enumeration and byte-count function SHALL live in shared package rom_pkg.
REQ-028 Storage SHALL be sub-module rom_byte_array (parameters DEPTH, INIT_FILE; 32-bit address in, 8-bit data out, combinational read).
REQ-029 Byte index counter SHALL be 2 bits; the address adder SHALL not exceed 33 bits.

Verification
REQ-030 Image bytes 0..7 = 11 22 33 44 85 66 77 88; req word @0 -> valid after 5 cycles, read_data=0x44332211, illegal=0.
REQ-031 req halfword @3, sign_extend=1 -> data 0xFFFF8544 after 3 cycles; sign_extend=0 -> 0x00008544.
REQ-032 DEPTH=512, req word @2045 -> valid after 1 cycle, illegal=1, data=0; byte @2047 -> legal; width=11 @0 -> illegal.
REQ-033 req word @0xFFFFFFFE -> illegal=1 (no wrap to legal range).
REQ-034 reset asserted 2 cycles into a word read -> no valid, outputs 0 asynchronously; subsequent byte @4 -> 0x00000085.
REQ-035 back-to-back req held high -> second access starts the cycle after valid; req pulses while busy produce no extra valid.
